// File: rtl/prog_timer.sv
// prog_timer: prescaled programmable timer, one-shot or periodic,
// with pause/resume/abort, expiry pulse, sticky irq and overrun.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start, stop       start/resume, pause/abort
//   clear             clears irq and overrun
//   mode              0 one-shot, 1 periodic (latched on start)
//   load_val          terminal count M (latched on start)
//   prescale          divider P, tick every P+1 cycles (latched)
//   count             live count value
//   busy              high in COUNT or PAUSE
//   done              one-cycle pulse per expiry
//   irq, overrun      sticky expiry / expiry-while-irq flags
module prog_timer #(
  parameter int DATA_WIDTH     = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      mode,
  input  logic [DATA_WIDTH-1:0]     load_val,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     count,
  output logic                      busy,
  output logic                      done,
  output logic                      irq,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_PAUSE,
    S_DONE
  } state_e;

  localparam logic [DATA_WIDTH-1:0]     C_ONE = 1;
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = 1;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [DATA_WIDTH-1:0]     m_q, m_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic                      mode_q, mode_d;
  logic                      done_q, done_d;
  logic                      irq_q, irq_d;
  logic                      ovr_q, ovr_d;

  logic tick;
  logic expire;
  logic launch;

  // M is never 0 while counting, so M-1 cannot underflow here.
  assign tick   = (state_q == S_COUNT) && (psc_q == p_q);
  assign expire = tick && (count_q == (m_q - C_ONE));
  assign launch = start && (load_val != '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    m_d     = m_q;
    p_d     = p_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          m_d     = load_val;
          p_d     = prescale;
          mode_d  = mode;
          count_d = '0;
          psc_d   = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // Expiry outranks a same-cycle stop.
        if (expire) begin
          done_d = 1'b1;
          psc_d  = '0;
          if (mode_q) begin
            count_d = '0;
          end else begin
            count_d = m_q;
            state_d = S_DONE;
          end
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          psc_d   = '0;
          count_d = count_q + C_ONE;
        end else begin
          psc_d = psc_q + P_ONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          count_d = '0;
          psc_d   = '0;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_COUNT;
        end
      end
      S_DONE: begin
        if (stop) begin
          count_d = '0;
          psc_d   = '0;
          state_d = S_IDLE;
        end else if (launch) begin
          m_d     = load_val;
          p_d     = prescale;
          mode_d  = mode;
          count_d = '0;
          psc_d   = '0;
          state_d = S_COUNT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set outranks clear for irq; overrun only latches when the
  // previous expiry is still unacknowledged.
  always_comb begin
    irq_d = irq_q;
    ovr_d = ovr_q;
    if (clear) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !clear) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      psc_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      m_q     <= m_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == S_COUNT) || (state_q == S_PAUSE);
  assign done    = done_q;
  assign irq     = irq_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed table-driven bench for prog_timer,
// plus hand-written periodic, corner-case and width sequences.
module tb_prog_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] load_val = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] count;
  logic        busy, done, irq, overrun;

  logic        st4 = 1'b0;
  logic        sp4 = 1'b0;
  logic        cl4 = 1'b0;
  logic        md4 = 1'b0;
  logic [3:0]  lv4 = '0;
  logic [7:0]  ps4 = '0;
  logic [3:0]  c4;
  logic        b4, d4, i4, o4;

  int n_cmp = 0;
  int n_err = 0;

  prog_timer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .mode     (mode),
    .load_val (load_val),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .irq      (irq),
    .overrun  (overrun)
  );

  prog_timer #(.DATA_WIDTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (st4),
    .stop     (sp4),
    .clear    (cl4),
    .mode     (md4),
    .load_val (lv4),
    .prescale (ps4),
    .count    (c4),
    .busy     (b4),
    .done     (d4),
    .irq      (i4),
    .overrun  (o4)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        st, sp, cl, md;
    logic [15:0] lv;
    logic [7:0]  ps;
    int          c, b, d, i, o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(int st, int sp, int cl, int md,
                             int lv, int ps, int c, int b,
                             int d, int i, int o);
    vec_t v;
    v.st = st[0];
    v.sp = sp[0];
    v.cl = cl[0];
    v.md = md[0];
    v.lv = lv[15:0];
    v.ps = ps[7:0];
    v.c  = c;
    v.b  = b;
    v.d  = d;
    v.i  = i;
    v.o  = o;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk_all(string nm, int c, int b, int d,
                         int i, int o);
    chk({nm, ".count"},   32'(count),   c);
    chk({nm, ".busy"},    32'(busy),    b);
    chk({nm, ".done"},    32'(done),    d);
    chk({nm, ".irq"},     32'(irq),     i);
    chk({nm, ".overrun"}, 32'(overrun), o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // one-shot M=5 P=0
    tbl.push_back(V(1,0,0,0, 5,0,  0,1,0,0,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(V(0,0,0,0, 5,0,  k,1,0,0,0));
    tbl.push_back(V(0,0,0,0, 5,0,  5,0,1,1,0));
    tbl.push_back(V(0,0,0,0, 5,0,  5,0,0,1,0));
    tbl.push_back(V(0,0,1,0, 5,0,  5,0,0,0,0));
    tbl.push_back(V(0,1,0,0, 5,0,  0,0,0,0,0));
    // pause / resume M=10 P=0
    tbl.push_back(V(1,0,0,0,10,0,  0,1,0,0,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(V(0,0,0,0,10,0,  k,1,0,0,0));
    tbl.push_back(V(0,1,0,0,10,0,  4,1,0,0,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(V(0,0,0,0,10,0,  4,1,0,0,0));
    tbl.push_back(V(1,0,0,0,10,0,  4,1,0,0,0));
    for (int k = 5; k <= 9; k++)
      tbl.push_back(V(0,0,0,0,10,0,  k,1,0,0,0));
    tbl.push_back(V(0,0,0,0,10,0, 10,0,1,1,0));
    tbl.push_back(V(0,0,0,0,10,0, 10,0,0,1,0));
    // restart from DONE, pause, then start+stop aborts
    tbl.push_back(V(1,0,0,0,10,0,  0,1,0,1,0));
    tbl.push_back(V(0,0,0,0,10,0,  1,1,0,1,0));
    tbl.push_back(V(0,0,0,0,10,0,  2,1,0,1,0));
    tbl.push_back(V(0,1,0,0,10,0,  2,1,0,1,0));
    tbl.push_back(V(1,1,0,0,10,0,  0,0,0,1,0));
    tbl.push_back(V(0,0,0,0,10,0,  0,0,0,1,0));
    // start with load_val=0 is ignored
    tbl.push_back(V(1,0,0,0, 0,0,  0,0,0,1,0));
    tbl.push_back(V(0,0,1,0, 0,0,  0,0,0,0,0));

    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;

    foreach (tbl[n]) begin
      start    = tbl[n].st;
      stop     = tbl[n].sp;
      clear    = tbl[n].cl;
      mode     = tbl[n].md;
      load_val = tbl[n].lv;
      prescale = tbl[n].ps;
      step();
      chk_all($sformatf("vec%0d", n), tbl[n].c, tbl[n].b,
              tbl[n].d, tbl[n].i, tbl[n].o);
    end
    start = 0; stop = 0; clear = 0;

    // periodic M=3 P=2; inputs change after start
    mode = 1; load_val = 3; prescale = 2; start = 1;
    step();
    chk_all("per.start", 0, 1, 0, 0, 0);
    start = 0; load_val = 7; prescale = 0; mode = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all($sformatf("per.k%0d", k), (k / 3) % 3, 1,
              int'(k % 9 == 0), int'(k >= 9), int'(k >= 18));
    end
    clear = 1;
    step();
    chk_all("per.clear", 1, 1, 0, 0, 0);
    clear = 0; stop = 1;
    step();
    chk_all("per.pause", 1, 1, 0, 0, 0);
    step();
    chk_all("per.abort", 0, 0, 0, 0, 0);
    stop = 0;

    // stop and clear in the expiry cycle
    mode = 0; load_val = 2; prescale = 0; start = 1;
    step();
    chk_all("sim.start", 0, 1, 0, 0, 0);
    start = 0;
    step();
    chk_all("sim.c1", 1, 1, 0, 0, 0);
    stop = 1;
    step();
    chk_all("sim.stopexp", 2, 0, 1, 1, 0);
    stop = 0;
    step();
    chk_all("sim.hold", 2, 0, 0, 1, 0);
    start = 1;
    step();
    chk_all("sim.restart", 0, 1, 0, 1, 0);
    start = 0;
    step();
    chk_all("sim.r1", 1, 1, 0, 1, 0);
    stop = 1; clear = 1;
    step();
    chk_all("sim.clrexp", 2, 0, 1, 1, 0);
    stop = 0; clear = 0;
    step();
    chk_all("sim.after", 2, 0, 0, 1, 0);

    // 4-bit instance, M = 2^4-1
    lv4 = 15; ps4 = 0; md4 = 0; st4 = 1;
    step();
    chk("w4.start.count", 32'(c4), 0);
    chk("w4.start.busy", 32'(b4), 1);
    st4 = 0; lv4 = 3; ps4 = 5;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("w4.k%0d.count", k), 32'(c4), k);
      chk($sformatf("w4.k%0d.done", k), 32'(d4),
          int'(k == 15));
    end
    step();
    chk("w4.hold.count", 32'(c4), 15);
    chk("w4.hold.busy", 32'(b4), 0);
    chk("w4.hold.irq", 32'(i4), 1);

    // async reset mid-count with irq set
    load_val = 10; start = 1;
    step();
    start = 0;
    step();
    step();
    step();
    chk_all("rst.pre", 3, 1, 0, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst.async", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    load_val = 2; start = 1;
    step();
    chk_all("rst.start", 0, 1, 0, 0, 0);
    start = 0;
    step();
    chk_all("rst.c1", 1, 1, 0, 0, 0);
    step();
    chk_all("rst.exp", 2, 0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
Parametrised successor to the team's single-shot timer: programmable-width counter with a clock prescaler, one-shot and periodic (auto-reload) modes, and pause/resume/abort control. It adds a live count readout, a one-cycle expiry pulse, a sticky interrupt flag with clear, and overrun detection. It sits beside control FSMs as a general-purpose delay and periodic-tick source.

Parameters:
DATA_WIDTH, 16, width of terminal value and count
PRESCALE_WIDTH, 8, width of prescale divider value

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  start from IDLE/DONE; resume from PAUSE
stop  input  1  pause from COUNT; abort from PAUSE/DONE
clear  input  1  clears irq and overrun
mode  input  1  0 = one-shot, 1 = periodic; latched on start
load_val  input  DATA_WIDTH  terminal count M; latched on start
prescale  input  PRESCALE_WIDTH  divider P, tick every P+1 cycles; latched on start
count  output  DATA_WIDTH  current count value
busy  output  1  high in COUNT or PAUSE
done  output  1  one-cycle pulse on each expiry
irq  output  1  sticky expiry flag
overrun  output  1  sticky: expiry while irq already set

Behaviour:
- Reset is asynchronous: state IDLE. count, psc, latched M/P/mode, done, irq and overrun all clear to 0, so busy = 0.
- States: IDLE, COUNT, PAUSE, DONE. busy = (state==COUNT || state==PAUSE).
- Internal prescale counter psc (PRESCALE_WIDTH bits). tick = (state==COUNT && psc==P_latched). On tick, psc<=0; otherwise in COUNT psc<=psc+1. With P=0, tick fires every COUNT cycle.
- IDLE: start with load_val!=0 latches M, P and mode, sets count<=0 and psc<=0, and moves to COUNT. start with load_val==0 is ignored and the block stays IDLE. stop is ignored.
- COUNT, tick with count==M-1 (expiry):
  - one-shot: count<=M, go to DONE.
  - periodic: count<=0, stay in COUNT.
  - Both modes: done<=1 for exactly one cycle.
- COUNT, tick with no expiry: count<=count+1.
- COUNT, stop: go to PAUSE with count and psc frozen. If expiry occurs in the same cycle, expiry wins and stop is ignored. start is ignored in COUNT.
- PAUSE: count and psc hold. start goes to COUNT and resumes exactly where it paused. stop aborts to IDLE with count<=0 and psc<=0. start and stop together: stop wins (abort).
- DONE: count holds at M. start restarts as from IDLE, relatching inputs. stop goes to IDLE with count<=0. start and stop together: stop wins.
- Latency: with start sampled at edge E0, count first becomes 1 at edge E0+(P+1). done is high during the cycle after edge E0+M*(P+1). In periodic mode, done repeats every M*(P+1) cycles.
- done is registered and driven from the same edge as the state/count update. done is 0 in every other cycle.
- irq: set on each expiry, cleared by clear. Expiry and clear in the same cycle leave irq=1 (set wins).
- overrun: set on an expiry when irq is already 1 and clear is not asserted that cycle; cleared by clear.
- Arithmetic: count never exceeds M. M = 2^DATA_WIDTH-1 is legal and must not wrap early. Latched values are unaffected by input changes after start.
- Reset mid-operation returns immediately to the reset values above; no pending done pulse survives.

Test Plan:
- One-shot: P=0, M=5, mode=0, start pulse at E0 -> count 1..5 on E1..E5; done high only in the cycle after E5; state DONE, count holds 5, irq=1, busy falls with the done pulse.
- Prescale and periodic: P=2, M=3, mode=1 -> done pulses every 9 cycles, count sequence 0,1,2 with 3 cycles each then back to 0. Without clear, overrun=1 after the second pulse.
- Pause/resume/abort: M=10, P=0. stop at count=4 -> count stays 4 for 6 cycles. start -> resumes, done at count 10. Repeat with a second stop while in PAUSE -> IDLE, count=0, no done.
- Simultaneous events: stop in the expiry cycle -> expiry taken (DONE, done pulse). clear in the expiry cycle -> irq remains 1, overrun unchanged. start with load_val=0 -> stays IDLE.
- Boundary width: DATA_WIDTH=4, M=15, P=0 -> done after 15 cycles, count reaches 15 without wrapping. Change load_val/prescale mid-count -> no effect.
- Async reset asserted mid-COUNT (count=3, irq=1), between clock edges -> all outputs 0 immediately. After release, start works normally.
